csr_unit: RTL



---
 rtl/csr_unit_pkg.sv | 60 ++++++
 rtl/csr_unit_counter.sv | 30 +++
 rtl/csr_unit.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/csr_unit_pkg.sv
// Shared constants for the machine-mode CSR file: privilege levels, trap
// cause codes, CSR addresses, writable-field masks and the Zicsr operation
// encoding.

package priv_levels;
  localparam logic [1:0] PRIV_USER       = 2'b00;
  localparam logic [1:0] PRIV_SUPERVISOR = 2'b01;
  localparam logic [1:0] PRIV_MACHINE    = 2'b11;
endpackage

package trap_causes;
  localparam logic [3:0] EXC_ILLEGAL_INSTR = 4'd2;
  localparam logic [3:0] EXC_ECALL_M       = 4'd11;
endpackage

package csr_addrs;
  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;
  localparam logic [11:0] CSR_MIMPID    = 12'hF13;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  // MIE[3], MPIE[7], MPP[12:11]
  localparam logic [63:0] MSTATUS_MASK = 64'h0000_0000_0000_1888;
  // MSIE[3], MTIE[7], MEIE[11]
  localparam logic [63:0] MIE_MASK     = 64'h0000_0000_0000_0888;
  // MXL=2 (RV64), extensions I and M
  localparam logic [63:0] MISA_VALUE   = 64'h8000_0000_0000_1100;

  // Zicsr operation in funct3[1:0]; funct3[2] selects the immediate form
  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_e;

  // Keep only the implemented mstatus fields; the reserved MPP encoding
  // 2'b10 collapses to user mode.
  function automatic logic [63:0] legalize_mstatus(input logic [63:0] value);
    logic [63:0] result;
    result = value & MSTATUS_MASK;
    if (result[12:11] == 2'b10) begin
      result[12:11] = 2'b00;
    end
    return result;
  endfunction
endpackage

// File: rtl/csr_unit_counter.sv
// Free-running 64-bit counter with a software load port; a load in the same
// cycle as an increment takes the loaded value and skips the increment.

module csr_counter #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;

  // Reset clears, a load beats the increment, increment wraps naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (wr_en) begin
      r_count <= wr_data;
    end else if (inc) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR file. Zicsr requests are decoded and answered in the same
// cycle; state (CSRs, privilege mode, counters) updates on the next edge with
// priority trap entry > xRET > CSR write.

module csr_unit
  import priv_levels::*;
  import trap_causes::*;
  import csr_addrs::*;
#(
  parameter int          XLEN        = 64,
  parameter logic [63:0] MTVEC_RESET = 64'h0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            csr_instr_valid,
  input  logic [11:0]     csr_addr,
  input  logic [2:0]      csr_funct3,
  input  logic [4:0]      csr_rd,
  input  logic [4:0]      csr_rs1_uimm,
  input  logic [XLEN-1:0] csr_rs1_data,
  output logic            csr_exception,
  output logic [3:0]      csr_trap_cause,
  output logic [XLEN-1:0] csr_result,
  input  logic            update_mstatus,
  input  logic [XLEN-1:0] new_mstatus,
  input  logic [1:0]      new_privilege_mode,
  input  logic            trap_enter,
  input  logic            trap_is_interrupt,
  input  logic [3:0]      trap_cause,
  input  logic [XLEN-1:0] trap_epc,
  input  logic [XLEN-1:0] trap_tval,
  input  logic            instret_inc,
  output logic [1:0]      privilege_mode,
  output logic [XLEN-1:0] mstatus,
  output logic [XLEN-1:0] mepc,
  output logic [XLEN-1:0] mtvec
);

  logic [1:0]      r_priv;
  logic [XLEN-1:0] r_mstatus;
  logic [XLEN-1:0] r_mie;
  logic [XLEN-1:0] r_mtvec;
  logic [XLEN-1:0] r_mscratch;
  logic [XLEN-1:0] r_mepc;
  logic [XLEN-1:0] r_mcause;
  logic [XLEN-1:0] r_mtval;

  logic [XLEN-1:0] w_mcycle;
  logic [XLEN-1:0] w_minstret;
  logic [XLEN-1:0] w_operand;
  csr_op_e         w_op;
  logic            w_writes;
  logic [XLEN-1:0] w_rdata;
  logic            w_implemented;
  logic            w_illegal;
  logic [XLEN-1:0] w_wdata;
  logic            w_do_write;
  logic [XLEN-1:0] w_trap_mstatus;
  logic            w_unused;

  // The destination index only matters to the register file
  assign w_unused = ^csr_rd;

  // Decode operation, operand source and whether the request writes
  always_comb begin
    w_operand = csr_funct3[2] ? {{(XLEN-5){1'b0}}, csr_rs1_uimm} : csr_rs1_data;
    w_op      = csr_op_e'(csr_funct3[1:0]);
    w_writes  = (w_op == CSR_OP_RW) || (csr_rs1_uimm != 5'd0);
  end

  // Read mux: current value of the addressed CSR, flags unknown addresses
  always_comb begin
    w_rdata       = '0;
    w_implemented = 1'b1;
    case (csr_addr)
      CSR_MSTATUS:                    w_rdata = r_mstatus;
      CSR_MISA:                       w_rdata = MISA_VALUE;
      CSR_MIE:                        w_rdata = r_mie;
      CSR_MTVEC:                      w_rdata = r_mtvec;
      CSR_MSCRATCH:                   w_rdata = r_mscratch;
      CSR_MEPC:                       w_rdata = r_mepc;
      CSR_MCAUSE:                     w_rdata = r_mcause;
      CSR_MTVAL:                      w_rdata = r_mtval;
      CSR_MCYCLE, CSR_CYCLE:          w_rdata = w_mcycle;
      CSR_MINSTRET, CSR_INSTRET:      w_rdata = w_minstret;
      CSR_MIP, CSR_MVENDORID, CSR_MARCHID,
      CSR_MIMPID, CSR_MHARTID:        w_rdata = '0;
      default:                        w_implemented = 1'b0;
    endcase
  end

  // Legality check and read-modify-write value before field masking
  always_comb begin
    w_illegal = !w_implemented
             || (w_op == CSR_OP_NONE)
             || (csr_addr[9:8] > r_priv)
             || ((csr_addr[11:10] == 2'b11) && w_writes);
    case (w_op)
      CSR_OP_RW: w_wdata = w_operand;
      CSR_OP_RS: w_wdata = w_rdata | w_operand;
      CSR_OP_RC: w_wdata = w_rdata & ~w_operand;
      default:   w_wdata = w_rdata;
    endcase
  end

  // mstatus after trap entry: stack MIE into MPIE, record the old mode
  always_comb begin
    w_trap_mstatus        = '0;
    w_trap_mstatus[12:11] = r_priv;
    w_trap_mstatus[7]     = r_mstatus[3];
  end

  assign csr_exception  = csr_instr_valid && w_illegal;
  assign csr_trap_cause = EXC_ILLEGAL_INSTR;
  assign csr_result     = w_rdata;
  // A trap on the same edge swallows the CSR write entirely
  assign w_do_write     = csr_instr_valid && !w_illegal && w_writes && !trap_enter;

  csr_counter #(.WIDTH(XLEN)) u_mcycle (
    .clk     (clk),
    .rst     (rst),
    .inc     (1'b1),
    .wr_en   (w_do_write && (csr_addr == CSR_MCYCLE)),
    .wr_data (w_wdata),
    .count   (w_mcycle)
  );

  csr_counter #(.WIDTH(XLEN)) u_minstret (
    .clk     (clk),
    .rst     (rst),
    .inc     (instret_inc),
    .wr_en   (w_do_write && (csr_addr == CSR_MINSTRET)),
    .wr_data (w_wdata),
    .count   (w_minstret)
  );

  // CSR and privilege state: reset > trap entry > xRET > software write
  always_ff @(posedge clk) begin
    if (rst) begin
      r_priv     <= PRIV_MACHINE;
      r_mstatus  <= '0;
      r_mie      <= '0;
      r_mtvec    <= MTVEC_RESET & ~64'h3;
      r_mscratch <= '0;
      r_mepc     <= '0;
      r_mcause   <= '0;
      r_mtval    <= '0;
    end else if (trap_enter) begin
      r_mepc    <= trap_epc & ~64'h3;
      r_mcause  <= {trap_is_interrupt, {(XLEN-5){1'b0}}, trap_cause};
      r_mtval   <= trap_tval;
      r_mstatus <= w_trap_mstatus;
      r_priv    <= PRIV_MACHINE;
    end else begin
      if (update_mstatus) begin
        r_mstatus <= legalize_mstatus(new_mstatus);
        r_priv    <= new_privilege_mode;
      end
      if (w_do_write) begin
        case (csr_addr)
          CSR_MSTATUS:  if (!update_mstatus) r_mstatus <= legalize_mstatus(w_wdata);
          CSR_MIE:      r_mie      <= w_wdata & MIE_MASK;
          CSR_MTVEC:    r_mtvec    <= w_wdata & ~64'h3;
          CSR_MSCRATCH: r_mscratch <= w_wdata;
          CSR_MEPC:     r_mepc     <= w_wdata & ~64'h3;
          CSR_MCAUSE:   r_mcause   <= w_wdata;
          CSR_MTVAL:    r_mtval    <= w_wdata;
          default:      ;
        endcase
      end
    end
  end

  assign privilege_mode = r_priv;
  assign mstatus        = r_mstatus;
  assign mepc           = r_mepc;
  assign mtvec          = r_mtvec;

endmodule
